// File: rtl/audio_rom_lut_if.sv
// Signal bundle between the wave generator and the audio ROM lookup block.
// The generator (master) drives the phase index and the note number; the ROM (slave) returns the sample and the note constants.
interface audio_rom_lut_if #(
    parameter int BITS = 6
);
    logic [9:0]      index;
    logic [4:0]      freq_id;
    logic [BITS-1:0] level;
    logic [15:0]     freq;
    logic [15:0]     period;

    modport master (
        output index,
        output freq_id,
        input  level,
        input  freq,
        input  period
    );

    modport slave (
        input  index,
        input  freq_id,
        output level,
        output freq,
        output period
    );
endinterface

// File: rtl/audio_rom_lut.sv
// Registered sine and note-constant lookup for the audio synthesiser.
// The sine path uses a quarter-wave table mirrored on index[9:8]; the note path is a 32-entry constant table.
module audio_rom_lut #(
    parameter int BITS = 6
) (
    input  logic            clock,
    input  logic            reset,
    audio_rom_lut_if.slave  bus
);
    localparam int AMP = (1 << (BITS - 1)) - 1;
    localparam logic [BITS-1:0] MID_L = {1'b0, {(BITS-1){1'b1}}};

    // AMP*sin(pi/2*j/256) rounded to nearest, from a Q30 Taylor series at elaboration time
    function automatic logic [BITS-2:0] quarter_amp(input int j);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint prod;
        x    = (64'sd1686629713 * longint'(j)) >>> 8;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
            acc  = acc + term;
        end
        prod = (acc * longint'(AMP) + 64'sd536870912) >>> 30;
        return prod[BITS-2:0];
    endfunction

    logic [BITS-2:0] quarter_s [0:256];

    for (genvar j = 0; j < 257; j++) begin : g_quarter
        assign quarter_s[j] = quarter_amp(j);
    end

    logic [BITS-1:0] level_d;
    logic [BITS-1:0] level_q;
    logic [15:0]     freq_d;
    logic [15:0]     freq_q;
    logic [15:0]     period_d;
    logic [15:0]     period_q;
    logic [BITS-2:0] amp_s;
    logic [8:0]      mirror_s;

    // Sine path: fold the phase into the first quadrant, then offset up or down from MID
    always_comb begin
        amp_s    = '0;
        level_d  = MID_L;
        mirror_s = 9'd256 - {1'b0, bus.index[7:0]};
        case (bus.index[9:8])
            2'd0: begin
                amp_s   = quarter_s[bus.index[7:0]];
                level_d = MID_L + {1'b0, amp_s};
            end
            2'd1: begin
                amp_s   = quarter_s[mirror_s];
                level_d = MID_L + {1'b0, amp_s};
            end
            2'd2: begin
                amp_s   = quarter_s[bus.index[7:0]];
                level_d = MID_L - {1'b0, amp_s};
            end
            2'd3: begin
                amp_s   = quarter_s[mirror_s];
                level_d = MID_L - {1'b0, amp_s};
            end
            default: begin
                amp_s   = '0;
                level_d = MID_L;
            end
        endcase
    end

    // Note path: freq = R(270*2^((k-12)/12)), period = R(65536/freq)
    always_comb begin
        freq_d   = 16'd0;
        period_d = 16'd0;
        case (bus.freq_id)
            5'd0:  begin freq_d = 16'd135; period_d = 16'd485; end
            5'd1:  begin freq_d = 16'd143; period_d = 16'd458; end
            5'd2:  begin freq_d = 16'd152; period_d = 16'd431; end
            5'd3:  begin freq_d = 16'd161; period_d = 16'd407; end
            5'd4:  begin freq_d = 16'd170; period_d = 16'd386; end
            5'd5:  begin freq_d = 16'd180; period_d = 16'd364; end
            5'd6:  begin freq_d = 16'd191; period_d = 16'd343; end
            5'd7:  begin freq_d = 16'd202; period_d = 16'd324; end
            5'd8:  begin freq_d = 16'd214; period_d = 16'd306; end
            5'd9:  begin freq_d = 16'd227; period_d = 16'd289; end
            5'd10: begin freq_d = 16'd241; period_d = 16'd272; end
            5'd11: begin freq_d = 16'd255; period_d = 16'd257; end
            5'd12: begin freq_d = 16'd270; period_d = 16'd243; end
            5'd13: begin freq_d = 16'd286; period_d = 16'd229; end
            5'd14: begin freq_d = 16'd303; period_d = 16'd216; end
            5'd15: begin freq_d = 16'd321; period_d = 16'd204; end
            5'd16: begin freq_d = 16'd340; period_d = 16'd193; end
            5'd17: begin freq_d = 16'd360; period_d = 16'd182; end
            5'd18: begin freq_d = 16'd382; period_d = 16'd172; end
            5'd19: begin freq_d = 16'd405; period_d = 16'd162; end
            5'd20: begin freq_d = 16'd429; period_d = 16'd153; end
            5'd21: begin freq_d = 16'd454; period_d = 16'd144; end
            5'd22: begin freq_d = 16'd481; period_d = 16'd136; end
            5'd23: begin freq_d = 16'd510; period_d = 16'd129; end
            5'd24: begin freq_d = 16'd540; period_d = 16'd121; end
            5'd25: begin freq_d = 16'd572; period_d = 16'd115; end
            5'd26: begin freq_d = 16'd606; period_d = 16'd108; end
            5'd27: begin freq_d = 16'd642; period_d = 16'd102; end
            5'd28: begin freq_d = 16'd680; period_d = 16'd96;  end
            5'd29: begin freq_d = 16'd721; period_d = 16'd91;  end
            5'd30: begin freq_d = 16'd764; period_d = 16'd86;  end
            5'd31: begin freq_d = 16'd809; period_d = 16'd81;  end
            default: begin freq_d = 16'd0; period_d = 16'd0; end
        endcase
    end

    // Output registers; reset clears them without waiting for a clock edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q  <= '0;
            freq_q   <= 16'd0;
            period_q <= 16'd0;
        end else begin
            level_q  <= level_d;
            freq_q   <= freq_d;
            period_q <= period_d;
        end
    end

    assign bus.level  = level_q;
    assign bus.freq   = freq_q;
    assign bus.period = period_q;
endmodule

// File: tb/tb_audio_rom_lut.sv
// Self-checking bench for audio_rom_lut: BITS=6 and BITS=8 instances against a real-arithmetic reference model.
module tb_audio_rom_lut;
    localparam real PI = 3.14159265358979323846;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   lv [0:1023];
    int   fr [0:31];
    int   pr [0:31];

    audio_rom_lut_if #(.BITS(6)) bus6 ();
    audio_rom_lut_if #(.BITS(8)) bus8 ();

    audio_rom_lut #(.BITS(6)) dut6 (.clock(clock), .reset(reset), .bus(bus6.slave));
    audio_rom_lut #(.BITS(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_level(input int bits, input int i);
        real amp;
        real v;
        int  r;
        amp = (2.0 ** (bits - 1)) - 1.0;
        v   = amp * $sin(2.0 * PI * real'(i) / 1024.0);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return $rtoi(amp) + r;
    endfunction

    function automatic int ref_freq(input int k);
        return $rtoi(270.0 * (2.0 ** (real'(k - 12) / 12.0)) + 0.5);
    endfunction

    function automatic int ref_period(input int k);
        return $rtoi(65536.0 / real'(ref_freq(k)) + 0.5);
    endfunction

    task automatic drive(input int idx, input int fid);
        bus6.index   = 10'(idx);
        bus8.index   = 10'(idx);
        bus6.freq_id = 5'(fid);
        bus8.freq_id = 5'(fid);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(256, 12);
        #2;
        check_eq("rst_level", bus6.level, 0);
        check_eq("rst_freq", bus6.freq, 0);
        check_eq("rst_period", bus6.period, 0);
        check_eq("rst_level8", bus8.level, 0);
        @(negedge clock);
        check_eq("rst_hold_level", bus6.level, 0);
        reset = 1'b0;
        step();
        check_eq("rel_level", bus6.level, 62);
        check_eq("rel_freq", bus6.freq, 270);
        check_eq("rel_period", bus6.period, 243);

        // cardinal points, BITS=6 and BITS=8
        for (int c = 0; c < 4; c++) begin
            drive(c * 256, 12);
            step();
            check_eq("card6", bus6.level, (c == 1) ? 62 : (c == 3) ? 0 : 31);
            check_eq("card8", bus8.level, (c == 1) ? 254 : (c == 3) ? 0 : 127);
        end

        // full sweep, back to back
        for (int i = 0; i < 1024; i++) begin
            drive(i, 12);
            step();
            lv[i] = int'(bus6.level);
            check_eq("sweep6", bus6.level, ref_level(6, i));
            check_eq("sweep8", bus8.level, ref_level(8, i));
        end
        for (int i = 0; i < 512; i++)
            check_eq("half_sym", lv[i] + lv[i + 512], 62);
        for (int i = 0; i <= 512; i++)
            check_eq("mirror_sym", lv[i], lv[512 - i]);

        // note table sweep
        for (int k = 0; k < 32; k++) begin
            drive(100, k);
            step();
            fr[k] = int'(bus6.freq);
            pr[k] = int'(bus6.period);
            check_eq("freq", bus6.freq, ref_freq(k));
            check_eq("period", bus6.period, ref_period(k));
            check_eq("prod_err", ((fr[k] * pr[k] - 65536 <= fr[k] / 2) &&
                                  (65536 - fr[k] * pr[k] <= fr[k] / 2)) ? 1 : 0, 1);
        end
        check_eq("anchor0", fr[0] * 1000 + pr[0], 135485);
        check_eq("anchor12", fr[12] * 1000 + pr[12], 270243);
        check_eq("anchor21", fr[21] * 1000 + pr[21], 454144);
        check_eq("anchor24", fr[24] * 1000 + pr[24], 540121);
        check_eq("anchor31", fr[31] * 1000 + pr[31], 809081);
        for (int k = 1; k < 32; k++) begin
            check_eq("freq_incr", (fr[k] > fr[k - 1]) ? 1 : 0, 1);
            check_eq("period_nonincr", (pr[k] <= pr[k - 1]) ? 1 : 0, 1);
        end

        // independence and latency
        drive(0, 12);
        step();
        check_eq("ind_pre_level", bus6.level, 31);
        drive(256, 24);
        step();
        check_eq("ind_freq", bus6.freq, 540);
        check_eq("ind_level", bus6.level, 62);
        drive(700, 24);
        step();
        check_eq("ind_keep_freq", bus6.freq, 540);
        check_eq("ind_keep_period", bus6.period, 121);
        check_eq("ind_new_level", bus6.level, ref_level(6, 700));

        // randomized stimulus
        for (int n = 0; n < 300; n++) begin
            int ri;
            int rk;
            ri = int'($urandom_range(1023, 0));
            rk = int'($urandom_range(31, 0));
            drive(ri, rk);
            step();
            check_eq("rnd_level6", bus6.level, ref_level(6, ri));
            check_eq("rnd_level8", bus8.level, ref_level(8, ri));
            check_eq("rnd_freq", bus6.freq, ref_freq(rk));
            check_eq("rnd_period", bus8.period, ref_period(rk));
        end

        // mid-stream reset clears outputs without a clock edge
        drive(256, 31);
        step();
        check_eq("pre_mrst_freq", bus6.freq, 809);
        reset = 1'b1;
        #1;
        check_eq("mrst_level", bus6.level, 0);
        check_eq("mrst_freq", bus6.freq, 0);
        check_eq("mrst_period", bus6.period, 0);
        check_eq("mrst_level8", bus8.level, 0);
        @(negedge clock);
        reset = 1'b0;
        step();
        check_eq("post_mrst_level", bus6.level, 62);
        check_eq("post_mrst_freq", bus6.freq, 809);
        check_eq("post_mrst_period", bus6.period, 81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
